// File: rtl/grid_raster_out.sv
// Rasterises a 64-cell board as a scaled pixel stream with line/frame sync.
// A board arrives into a one-entry shadow buffer and is shown from the next frame boundary.
module grid_raster_out #(
    parameter int unsigned GRID_W   = 8,
    parameter int unsigned GRID_H   = 8,
    parameter int unsigned CELL_PIX = 4,
    parameter int unsigned H_BLANK  = 8,
    parameter int unsigned V_BLANK  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [63:0]                 grid_in,
    input  logic                        grid_valid,
    output logic                        grid_ready,
    output logic                        pix_valid,
    output logic                        pix_on,
    output logic [$clog2(GRID_W)-1:0]   pix_x,
    output logic [$clog2(GRID_H)-1:0]   pix_y,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        frame_done
);

    localparam int unsigned H_ACT = GRID_W * CELL_PIX;
    localparam int unsigned V_ACT = GRID_H * CELL_PIX;
    localparam int unsigned HT    = H_ACT + H_BLANK;
    localparam int unsigned VT    = V_ACT + V_BLANK;
    localparam int unsigned NCELL = GRID_W * GRID_H;
    localparam int unsigned HW    = $clog2(HT);
    localparam int unsigned VW    = $clog2(VT);
    localparam int unsigned XW    = $clog2(GRID_W);
    localparam int unsigned YW    = $clog2(GRID_H);
    localparam int unsigned CW    = $clog2(NCELL);

    localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACT);
    localparam logic [HW-1:0] H_LAST_L = HW'(HT - 1);
    localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACT);
    localparam logic [VW-1:0] V_LAST_L = VW'(VT - 1);

    logic          run_q,     run_d;
    logic [HW-1:0] h_q,       h_d;
    logic [VW-1:0] v_q,       v_d;
    logic          pending_q, pending_d;
    logic [63:0]   shadow_q,  shadow_d;
    logic [63:0]   active_q,  active_d;

    logic          pix_valid_c;
    logic          pix_on_c;
    logic [XW-1:0] pix_x_c;
    logic [YW-1:0] pix_y_c;
    logic          hsync_c;
    logic          vsync_c;
    logic          frame_done_c;
    logic [CW-1:0] cell_idx_c;
    logic [CW-1:0] cell_bit_c;

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q     <= 1'b0;
            h_q       <= '0;
            v_q       <= '0;
            pending_q <= 1'b0;
            shadow_q  <= '0;
            active_q  <= '0;
        end else begin
            run_q     <= run_d;
            h_q       <= h_d;
            v_q       <= v_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
        end
    end

    // Output decode straight from the registered scan position
    always_comb begin
        pix_valid_c  = run_q && (h_q < H_ACT_L) && (v_q < V_ACT_L);
        pix_x_c      = '0;
        pix_y_c      = '0;
        if (pix_valid_c) begin
            pix_x_c = XW'(h_q / HW'(CELL_PIX));
            pix_y_c = YW'(v_q / VW'(CELL_PIX));
        end
        // bit 63 holds cell (0,0), so the board is indexed from the top
        cell_idx_c   = CW'(pix_y_c) * CW'(GRID_W) + CW'(pix_x_c);
        cell_bit_c   = CW'(NCELL - 1) - cell_idx_c;
        pix_on_c     = pix_valid_c && active_q[cell_bit_c];
        hsync_c      = run_q && (h_q == H_ACT_L);
        vsync_c      = run_q && (v_q == V_ACT_L);
        frame_done_c = run_q && (h_q == H_LAST_L) && (v_q == V_LAST_L);
    end

    // Scan counters, handshake and frame-boundary swap
    always_comb begin
        run_d     = start;
        h_d       = '0;
        v_d       = '0;
        pending_d = pending_q;
        shadow_d  = shadow_q;
        active_d  = active_q;

        if (run_q) begin
            if (h_q == H_LAST_L) begin
                h_d = '0;
                v_d = (v_q == V_LAST_L) ? '0 : v_q + VW'(1);
            end else begin
                h_d = h_q + HW'(1);
                v_d = v_q;
            end
        end

        // Accept and swap are exclusive: one needs pending clear, the other set
        if (grid_valid && !pending_q) begin
            shadow_d  = grid_in;
            pending_d = 1'b1;
        end
        if (frame_done_c && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
    end

    assign grid_ready = ~pending_q;
    assign pix_valid  = pix_valid_c;
    assign pix_on     = pix_on_c;
    assign pix_x      = pix_x_c;
    assign pix_y      = pix_y_c;
    assign hsync      = hsync_c;
    assign vsync      = vsync_c;
    assign frame_done = frame_done_c;

endmodule

// File: tb/tb_grid_raster_out.sv
// Directed bench for grid_raster_out: handshake, frame-boundary swap, scan timing,
// scan stop/restart and asynchronous reset.
module tb_grid_raster_out;

    localparam logic [63:0] BOARD_A = 64'h0412_6424_0034_3C28;
    localparam logic [63:0] BOARD_B = 64'hFF00_0000_0000_0000;
    localparam logic [63:0] BOARD_C = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] BOARD_D = 64'h8000_0000_0000_0001;
    localparam logic [63:0] BOARD_E = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] BOARD_F = 64'h00FF_00FF_00FF_00FF;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] grid_in;
    logic        grid_valid;
    logic        grid_ready;
    logic        pix_valid;
    logic        pix_on;
    logic [2:0]  pix_x;
    logic [2:0]  pix_y;
    logic        hsync;
    logic        vsync;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    grid_raster_out dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .grid_in    (grid_in),
        .grid_valid (grid_valid),
        .grid_ready (grid_ready),
        .pix_valid  (pix_valid),
        .pix_on     (pix_on),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .hsync      (hsync),
        .vsync      (vsync),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Walks one 1440-cycle frame from h=0,v=0, ending on the frame_done negedge.
    task automatic scan_frame(input logic [63:0] board, output int n_on, output int n_val,
                              output int n_hs, output int n_vs, output int n_fd, output int n_pos);
        int   hc, vc, ex, ey;
        logic ev, eon;
        n_on = 0; n_val = 0; n_hs = 0; n_vs = 0; n_fd = 0; n_pos = 0;
        for (int i = 0; i < 1440; i++) begin
            hc  = i % 40;
            vc  = i / 40;
            ev  = (hc < 32) && (vc < 32);
            ex  = ev ? hc / 4 : 0;
            ey  = ev ? vc / 4 : 0;
            eon = ev && board[63 - (ey * 8 + ex)];
            if (pix_on === 1'b1)     n_on++;
            if (pix_valid === 1'b1)  n_val++;
            if (hsync === 1'b1)      n_hs++;
            if (vsync === 1'b1)      n_vs++;
            if (frame_done === 1'b1) n_fd++;
            if (pix_valid !== ev || pix_on !== eon || hsync !== (hc == 32) ||
                vsync !== (vc == 32) || frame_done !== (hc == 39 && vc == 35) ||
                pix_x !== 3'(ex) || pix_y !== 3'(ey))
                n_pos++;
            if (i < 1439) @(negedge clk);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_on, n_val, n_hs, n_vs, n_fd, n_pos, errs, cnt;

        reset = 1'b0; start = 1'b0; grid_valid = 1'b0; grid_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(grid_ready), 64'd1);
        chk("rst_outs", 64'({pix_valid, pix_on, hsync, vsync, frame_done, pix_x, pix_y}), 64'd0);

        // Idle with start low
        reset = 1'b1;
        errs = 0;
        repeat (100) begin
            @(negedge clk);
            if ({pix_valid, pix_on, hsync, vsync, frame_done} !== 5'b0 || grid_ready !== 1'b1) errs++;
        end
        chk("idle_errs", 64'(errs), 64'd0);

        // Board A handshake together with scan start
        grid_in = BOARD_A; grid_valid = 1'b1; start = 1'b1;
        @(negedge clk);
        grid_valid = 1'b0;
        chk("a_ready_fall", 64'(grid_ready), 64'd0);
        scan_frame(64'd0, n_on, n_val, n_hs, n_vs, n_fd, n_pos);
        chk("f1_pos", 64'(n_pos), 64'd0);
        chk("f1_on", 64'(n_on), 64'd0);
        chk("f1_valid", 64'(n_val), 64'd1024);
        chk("f1_hsync", 64'(n_hs), 64'd36);
        chk("f1_vsync", 64'(n_vs), 64'd40);
        chk("f1_fdone", 64'(n_fd), 64'd1);
        chk("f1_ready_at_fd", 64'(grid_ready), 64'd0);
        @(negedge clk);
        chk("f2_ready_rise", 64'(grid_ready), 64'd1);
        scan_frame(BOARD_A, n_on, n_val, n_hs, n_vs, n_fd, n_pos);
        chk("f2_pos", 64'(n_pos), 64'd0);
        chk("f2_on", 64'(n_on), 64'd272);
        chk("f2_fdone", 64'(n_fd), 64'd1);

        // Board B taken, board C offered while pending must be ignored
        @(negedge clk);
        chk("f3_ready", 64'(grid_ready), 64'd1);
        grid_in = BOARD_B; grid_valid = 1'b1;
        @(negedge clk);
        chk("b_ready_fall", 64'(grid_ready), 64'd0);
        grid_in = BOARD_C;
        errs = 0;
        repeat (5) begin
            @(negedge clk);
            if (grid_ready !== 1'b0) errs++;
        end
        grid_valid = 1'b0;
        chk("c_blocked", 64'(errs), 64'd0);
        cnt = 0;
        while (frame_done !== 1'b1 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        chk("f3_period", 64'(cnt), 64'd1433);
        chk("f3_ready_at_fd", 64'(grid_ready), 64'd0);
        @(negedge clk);
        chk("f4_ready", 64'(grid_ready), 64'd1);
        scan_frame(BOARD_B, n_on, n_val, n_hs, n_vs, n_fd, n_pos);
        chk("f4_pos", 64'(n_pos), 64'd0);
        chk("f4_on", 64'(n_on), 64'd128);

        // Board D offered on the frame_done cycle itself
        grid_in = BOARD_D; grid_valid = 1'b1;
        @(negedge clk);
        grid_valid = 1'b0;
        chk("d_ready_fall", 64'(grid_ready), 64'd0);
        scan_frame(BOARD_B, n_on, n_val, n_hs, n_vs, n_fd, n_pos);
        chk("f5_pos", 64'(n_pos), 64'd0);
        chk("f5_on", 64'(n_on), 64'd128);
        @(negedge clk);
        chk("f6_ready", 64'(grid_ready), 64'd1);
        scan_frame(BOARD_D, n_on, n_val, n_hs, n_vs, n_fd, n_pos);
        chk("f6_pos", 64'(n_pos), 64'd0);
        chk("f6_on", 64'(n_on), 64'd32);

        // Stop scan at h=10,v=5 with board E pending
        @(negedge clk);
        grid_in = BOARD_E; grid_valid = 1'b1;
        @(negedge clk);
        grid_valid = 1'b0;
        repeat (209) @(negedge clk);
        chk("stop_pos", 64'({pix_valid, pix_x, pix_y}), 64'({1'b1, 3'd2, 3'd1}));
        start = 1'b0;
        @(negedge clk);
        chk("stop_outs", 64'({pix_valid, pix_on, hsync, vsync, frame_done}), 64'd0);
        errs = 0;
        repeat (1500) begin
            @(negedge clk);
            if ({pix_valid, pix_on, hsync, vsync, frame_done} !== 5'b0 || grid_ready !== 1'b0) errs++;
        end
        chk("stop_idle", 64'(errs), 64'd0);
        start = 1'b1;
        @(negedge clk);
        scan_frame(BOARD_D, n_on, n_val, n_hs, n_vs, n_fd, n_pos);
        chk("restart_pos", 64'(n_pos), 64'd0);
        chk("restart_on", 64'(n_on), 64'd32);

        // Asynchronous reset mid-frame with board F pending
        @(negedge clk);
        grid_in = BOARD_F; grid_valid = 1'b1;
        @(negedge clk);
        grid_valid = 1'b0;
        repeat (100) @(negedge clk);
        chk("pre_rst_pix", 64'({pix_valid, pix_on, grid_ready}), 64'({1'b1, 1'b1, 1'b0}));
        #2 reset = 1'b0;
        #1;
        chk("async_outs", 64'({pix_valid, pix_on, hsync, vsync, frame_done, pix_x, pix_y}), 64'd0);
        chk("async_ready", 64'(grid_ready), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        scan_frame(64'd0, n_on, n_val, n_hs, n_vs, n_fd, n_pos);
        chk("post_rst_pos", 64'(n_pos), 64'd0);
        chk("post_rst_on", 64'(n_on), 64'd0);
        chk("post_rst_ready", 64'(grid_ready), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
